// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared definitions for the async FIFO write/read-side controllers.
package fifo_wr_ctrl_pkg;

  // Burst controller state codes; the read-side controller reuses the same encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StStall = 2'd2,
    StDone  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// Gray-code to binary converter; each binary bit is the XOR of all gray bits at or above it.
module gray2bin #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  // Prefix XOR from the MSB down, written per bit to avoid a self-referencing vector.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < N; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side burst controller for the async FIFO (wclk domain, falling-edge flops).
// Feeds beats to the pointer stage/RAM, stalls on full with an optional timeout,
// and reports registered occupancy derived from the gray pointers.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = 5,
  parameter int unsigned DSIZE        = 8,
  parameter int unsigned LENW         = 8,
  parameter int unsigned AFULL_THRESH = 28,
  parameter int unsigned STALL_W      = 8,
  parameter int unsigned STALL_MAX    = 255
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                cmd_valid,
  input  logic [LENW-1:0]     cmd_len,
  output logic                cmd_ready,
  input  logic                in_valid,
  input  logic [DSIZE-1:0]    in_data,
  output logic                in_ready,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                almost_full,
  output logic                burst_done,
  output logic                burst_abort,
  output logic                timeout_err,
  output logic                len_err,
  input  logic                err_clr
);

  // Stall count at which a still-full FIFO aborts the burst (only used when STALL_MAX != 0).
  localparam logic [STALL_W-1:0] StallLast = STALL_W'(STALL_MAX - 1);
  localparam logic [LENW-1:0]    LenOne    = LENW'(1);

  wr_state_e          state_q, state_d;
  logic [LENW-1:0]    remaining_q, remaining_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               done_d, abort_d;
  logic               timeout_set, len_set;

  logic [ADDRSIZE:0]  wptr_bin, rptr_bin, level_d;

  // Beat handshake is purely combinational so a full FIFO never drops an accepted beat.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    in_ready  = (state_q == StBurst) & ~wfull;
    winc      = in_valid & in_ready;
    wdata     = in_data;
  end

  // Next-state logic for the burst FSM and its counters.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    stall_cnt_d = stall_cnt_q;
    abort_d     = 1'b0;
    timeout_set = 1'b0;
    len_set     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            remaining_d = cmd_len;
            state_d     = StBurst;
          end else begin
            len_set = 1'b1;
          end
        end
      end
      StBurst: begin
        if (wfull) begin
          state_d = StStall;
        end else if (winc) begin
          remaining_d = remaining_q - LenOne;
          if (remaining_q == LenOne) begin
            state_d = StDone;
          end
        end
      end
      StStall: begin
        if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!wfull) begin
          // Return to BURST costs one bubble cycle with in_ready low.
          state_d     = StBurst;
          stall_cnt_d = '0;
        end else if ((STALL_MAX != 0) && (stall_cnt_q == StallLast)) begin
          state_d     = StDone;
          abort_d     = 1'b1;
          timeout_set = 1'b1;
        end
      end
      StDone: begin
        state_d     = StIdle;
        remaining_d = '0;
        stall_cnt_d = '0;
      end
    endcase
    done_d = (state_d == StDone);
  end

  // FSM, counter and pulse registers; done/abort are high exactly during the DONE cycle.
  always_ff @(negedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      stall_cnt_q <= '0;
      burst_done  <= 1'b0;
      burst_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      stall_cnt_q <= stall_cnt_d;
      burst_done  <= done_d;
      burst_abort <= abort_d;
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(negedge wclk or posedge wrst) begin
    if (wrst) begin
      timeout_err <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
      if (len_set) begin
        len_err <= 1'b1;
      end else if (err_clr) begin
        len_err <= 1'b0;
      end
    end
  end

  gray2bin #(
    .N (ADDRSIZE + 1)
  ) u_wptr_g2b (
    .gray_i (wptr),
    .bin_o  (wptr_bin)
  );

  gray2bin #(
    .N (ADDRSIZE + 1)
  ) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rptr_bin)
  );

  // Modular subtraction handles pointer wrap; the extra MSB distinguishes full from empty.
  assign level_d = wptr_bin - rptr_bin;

  // Registered occupancy and almost-full, updated together.
  always_ff @(negedge wclk or posedge wrst) begin
    if (wrst) begin
      wlevel      <= '0;
      almost_full <= 1'b0;
    end else begin
      wlevel      <= level_d;
      almost_full <= (32'(level_d) >= AFULL_THRESH);
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with a data scoreboard on the winc/wdata stream.
module tb_fifo_wr_ctrl;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_len = '0;
  logic       cmd_ready;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       wfull = 1'b0;
  logic [5:0] wptr = '0;
  logic [5:0] wq2_rptr = '0;
  logic       winc;
  logic [7:0] wdata;
  logic [5:0] wlevel;
  logic       almost_full;
  logic       burst_done;
  logic       burst_abort;
  logic       timeout_err;
  logic       len_err;
  logic       err_clr = 1'b0;

  int         n_assert = 0;
  int         n_fail = 0;
  int         winc_cnt = 0;
  int         winc_base;
  logic [7:0] exp_q[$];

  fifo_wr_ctrl #(
    .ADDRSIZE     (5),
    .DSIZE        (8),
    .LENW         (8),
    .AFULL_THRESH (28),
    .STALL_W      (8),
    .STALL_MAX    (5)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .cmd_valid   (cmd_valid),
    .cmd_len     (cmd_len),
    .cmd_ready   (cmd_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .wfull       (wfull),
    .wptr        (wptr),
    .wq2_rptr    (wq2_rptr),
    .winc        (winc),
    .wdata       (wdata),
    .wlevel      (wlevel),
    .almost_full (almost_full),
    .burst_done  (burst_done),
    .burst_abort (burst_abort),
    .timeout_err (timeout_err),
    .len_err     (len_err),
    .err_clr     (err_clr)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard sample mid-cycle, then advance past the next falling (active) edge.
  task automatic tick();
    #1;
    if (winc === 1'b1) begin
      winc_cnt++;
      if (exp_q.size() == 0) check("winc_spurious", 32'(winc), 32'd0);
      else check("wdata", 32'(wdata), 32'(exp_q.pop_front()));
    end
    @(negedge wclk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    #1;
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Present one beat expected to be accepted this cycle.
  task automatic send_beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    #1;
    check("beat_in_ready", 32'(in_ready), 32'd1);
    check("beat_winc", 32'(winc), 32'd1);
    tick();
  endtask

  initial begin
    // Reset state
    @(negedge wclk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_burst_done", 32'(burst_done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_wlevel", 32'(wlevel), 32'd0);
    wrst = 1'b0;
    tick();

    // Plain 4-beat burst, back-to-back beats, done pulse after the last
    winc_base = winc_cnt;
    send_cmd(8'd4);
    for (int i = 0; i < 4; i++) send_beat(8'hA0 + 8'(i));
    in_valid = 1'b0;
    #1;
    check("b2_done", 32'(burst_done), 32'd1);
    check("b2_abort", 32'(burst_abort), 32'd0);
    check("b2_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("b2_winc_total", 32'(winc_cnt - winc_base), 32'd4);
    check("b2_done_gone", 32'(burst_done), 32'd0);
    check("b2_idle", 32'(cmd_ready), 32'd1);

    // Full for 3 cycles after beat 2, then resume
    winc_base = winc_cnt;
    send_cmd(8'd4);
    send_beat(8'h30);
    send_beat(8'h31);
    wfull    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h32;
    exp_q.push_back(8'h32);
    #1;
    check("b3_full_in_ready", 32'(in_ready), 32'd0);
    check("b3_full_winc", 32'(winc), 32'd0);
    tick();
    check("b3_stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    wfull = 1'b0;
    #1;
    check("b3_bubble", 32'(in_ready), 32'd0);
    tick();
    #1;
    check("b3_resume", 32'(in_ready), 32'd1);
    tick();
    send_beat(8'h33);
    in_valid = 1'b0;
    #1;
    check("b3_done", 32'(burst_done), 32'd1);
    check("b3_abort", 32'(burst_abort), 32'd0);
    check("b3_winc_total", 32'(winc_cnt - winc_base), 32'd4);
    tick();
    check("b3_no_timeout", 32'(timeout_err), 32'd0);

    // Timeout with STALL_MAX=5
    send_cmd(8'd4);
    send_beat(8'h40);
    in_valid = 1'b0;
    wfull    = 1'b1;
    #1;
    check("b4_full_in_ready", 32'(in_ready), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("b4_no_early_done", 32'(burst_done), 32'd0);
      tick();
    end
    check("b4_done", 32'(burst_done), 32'd1);
    check("b4_abort", 32'(burst_abort), 32'd1);
    check("b4_timeout_set", 32'(timeout_err), 32'd1);
    wfull = 1'b0;
    tick();
    check("b4_done_gone", 32'(burst_done), 32'd0);
    check("b4_abort_gone", 32'(burst_abort), 32'd0);
    check("b4_idle", 32'(cmd_ready), 32'd1);
    tick();
    check("b4_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("b4_cleared", 32'(timeout_err), 32'd0);
    check("b4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length command
    winc_base = winc_cnt;
    send_cmd(8'd0);
    check("b5_len_err", 32'(len_err), 32'd1);
    check("b5_still_idle", 32'(cmd_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    #1;
    check("b5_no_winc", 32'(winc), 32'd0);
    tick();
    in_valid = 1'b0;
    check("b5_no_done", 32'(burst_done), 32'd0);
    err_clr   = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    tick();
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    check("b5_set_wins", 32'(len_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("b5_cleared", 32'(len_err), 32'd0);
    check("b5_winc_total", 32'(winc_cnt - winc_base), 32'd0);

    // Reset mid-burst after 2 of 4 beats
    wptr = 6'b000011;
    send_cmd(8'd4);
    send_beat(8'h60);
    send_beat(8'h61);
    check("b1_level_pre", 32'(wlevel), 32'd2);
    in_valid = 1'b1;
    in_data  = 8'h62;
    wrst     = 1'b1;
    #1;
    check("b1_in_ready", 32'(in_ready), 32'd0);
    check("b1_winc", 32'(winc), 32'd0);
    check("b1_cmd_ready", 32'(cmd_ready), 32'd1);
    check("b1_wlevel", 32'(wlevel), 32'd0);
    check("b1_done", 32'(burst_done), 32'd0);
    tick();
    wrst     = 1'b0;
    in_valid = 1'b0;
    tick();
    check("b1_level_post", 32'(wlevel), 32'd2);
    wptr = '0;
    winc_base = winc_cnt;
    send_cmd(8'd2);
    send_beat(8'h70);
    send_beat(8'h71);
    #1;
    check("b1_new_done", 32'(burst_done), 32'd1);
    check("b1_new_total", 32'(winc_cnt - winc_base), 32'd2);
    tick();

    // Occupancy from gray pointers
    wptr     = 6'b110010;  // 35
    wq2_rptr = 6'b000100;  // 7
    #1;
    check("b6_latency", 32'(wlevel), 32'd0);
    tick();
    check("b6_level28", 32'(wlevel), 32'd28);
    check("b6_af28", 32'(almost_full), 32'd1);
    wptr = 6'b110011;      // 34 -> level 27
    tick();
    check("b6_level27", 32'(wlevel), 32'd27);
    check("b6_af27", 32'(almost_full), 32'd0);
    wptr     = 6'b000011;  // 2
    wq2_rptr = 6'b100010;  // 60
    tick();
    check("b6_wrap_level", 32'(wlevel), 32'd6);
    check("b6_wrap_af", 32'(almost_full), 32'd0);
    wptr     = 6'b110000;  // 32
    wq2_rptr = 6'b000000;
    tick();
    check("b6_full_level", 32'(wlevel), 32'd32);
    check("b6_full_af", 32'(almost_full), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
